lsu_sequencer: RTL

Multi-cycle load/store sequencer between the RV32I execute stage and the single-port data bus. Accepts one decoded LOAD/STORE request at a time (opcode plus funct3), issues one or two word-aligned bus transactions with byte-lane masks, then returns a sign/zero-extended load result or a store completion. It sits after address generation and arbitrates nothing else: one outstanding request, in order.

---
 rtl/lsu_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_sequencer.sv
// lsu_sequencer: RV32I load/store sequencer issuing one or two word-aligned bus beats per request.
// Build option: define LSU_SPLIT_MISALIGNED_EN to execute word-crossing accesses as two beats.

module lsu_sequencer #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            req_op,
  input  logic [2:0]            req_f3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_we,
  output logic [3:0]            bus_wmask,
  output logic [31:0]           bus_wdata,
  input  logic                  bus_rvalid,
  input  logic [31:0]           bus_rdata,
  output logic                  rsp_valid,
  output logic [4:0]            rsp_rd,
  output logic [31:0]           rsp_data,
  output logic                  rsp_err
);

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

`ifdef LSU_SPLIT_MISALIGNED_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ1  = 3'd1,
    S_WAIT1 = 3'd2,
    S_REQ2  = 3'd3,
    S_WAIT2 = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  function automatic logic is_illegal(input logic [4:0] op, input logic [2:0] f3);
    logic bad;
    if (op == OP_LOAD) begin
      bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    end else if (op == OP_STORE) begin
      bad = (f3 >= 3'd3);
    end else begin
      bad = 1'b1;
    end
    return bad;
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    logic [3:0] m;
    case (sz)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      2'd2:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] w);
    logic [31:0] r;
    case (f3)
      3'd0:    r = {{24{w[7]}}, w[7:0]};
      3'd1:    r = {{16{w[15]}}, w[15:0]};
      3'd2:    r = w;
      3'd4:    r = {24'h000000, w[7:0]};
      3'd5:    r = {16'h0000, w[15:0]};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  state_t                  state_r;
  state_t                  next_state_s;
  logic                    is_load_r;
  logic [2:0]              f3_r;
  logic [1:0]              off_r;
  logic [4:0]              rd_r;
  logic [7:0]              mask8_r;
  logic [63:0]             wdata64_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic                    split_r;
  logic [31:0]             rdata_lo_r;

  logic                    accept_s;
  logic                    illegal_s;
  logic                    split_req_s;
  logic                    is_store_req_s;
  logic [7:0]              mask8_s;
  logic [63:0]             wdata64_s;
  logic [ADDR_WIDTH-1:0]   base_addr_s;
  logic                    beat1_rx_s;
  logic [31:0]             lo_s;
  logic [31:0]             hi_s;
  logic [31:0]             load_word_s;

  logic                    req_ready_s;
  logic                    bus_valid_s;
  logic [ADDR_WIDTH-1:0]   bus_addr_s;
  logic                    bus_we_s;
  logic [3:0]              bus_wmask_s;
  logic [31:0]             bus_wdata_s;
  logic                    rsp_valid_s;
  logic [4:0]              rsp_rd_s;
  logic [31:0]             rsp_data_s;
  logic                    rsp_err_s;

  // Request decode and lane placement computed from the live request fields.
  always_comb begin
    accept_s       = (state_r == S_IDLE) && req_ready && req_valid;
    illegal_s      = is_illegal(req_op, req_f3);
    is_store_req_s = (req_op == OP_STORE);
    mask8_s        = {4'b0000, size_mask(req_f3[1:0])} << req_addr[1:0];
    wdata64_s      = {32'h0000_0000, req_wdata} << {req_addr[1:0], 3'b000};
    split_req_s    = |mask8_s[7:4];
    base_addr_s    = {req_addr[ADDR_WIDTH-1:2], 2'b00};
    beat1_rx_s     = is_load_r && bus_rvalid &&
                     (((state_r == S_REQ1) && bus_ready) || (state_r == S_WAIT1));
  end

  // Load data assembly: the beat arriving now is combined with any earlier captured beat.
  always_comb begin
    if ((state_r == S_REQ2) || (state_r == S_WAIT2)) begin
      lo_s = rdata_lo_r;
      hi_s = bus_rdata;
    end else begin
      lo_s = bus_rdata;
      hi_s = 32'h0000_0000;
    end
    load_word_s = 32'({hi_s, lo_s} >> {off_r, 3'b000});
  end

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (illegal_s || (split_req_s && !SPLIT_EN)) begin
            next_state_s = S_RESP;
          end else begin
            next_state_s = S_REQ1;
          end
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_REQ1: begin
        if (!bus_ready) begin
          next_state_s = S_REQ1;
        end else if (is_load_r && !bus_rvalid) begin
          next_state_s = S_WAIT1;
        end else begin
          next_state_s = split_r ? S_REQ2 : S_RESP;
        end
      end
      S_WAIT1: begin
        if (bus_rvalid) begin
          next_state_s = split_r ? S_REQ2 : S_RESP;
        end else begin
          next_state_s = S_WAIT1;
        end
      end
      S_REQ2: begin
        if (!bus_ready) begin
          next_state_s = S_REQ2;
        end else if (is_load_r && !bus_rvalid) begin
          next_state_s = S_WAIT2;
        end else begin
          next_state_s = S_RESP;
        end
      end
      S_WAIT2: begin
        if (bus_rvalid) begin
          next_state_s = S_RESP;
        end else begin
          next_state_s = S_WAIT2;
        end
      end
      S_RESP:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered bus and response outputs.
  always_comb begin
    req_ready_s = (next_state_s == S_IDLE);
    bus_valid_s = 1'b0;
    bus_addr_s  = '0;
    bus_we_s    = 1'b0;
    bus_wmask_s = 4'h0;
    bus_wdata_s = 32'h0000_0000;
    rsp_valid_s = 1'b0;
    rsp_rd_s    = 5'd0;
    rsp_data_s  = 32'h0000_0000;
    rsp_err_s   = 1'b0;
    case (next_state_s)
      S_REQ1: begin
        if (state_r == S_IDLE) begin
          bus_valid_s = 1'b1;
          bus_addr_s  = base_addr_s;
          bus_we_s    = is_store_req_s;
          bus_wmask_s = mask8_s[3:0];
          bus_wdata_s = is_store_req_s ? wdata64_s[31:0] : 32'h0000_0000;
        end else begin
          bus_valid_s = bus_valid;
          bus_addr_s  = bus_addr;
          bus_we_s    = bus_we;
          bus_wmask_s = bus_wmask;
          bus_wdata_s = bus_wdata;
        end
      end
      S_REQ2: begin
        if (state_r == S_REQ2) begin
          bus_valid_s = bus_valid;
          bus_addr_s  = bus_addr;
          bus_we_s    = bus_we;
          bus_wmask_s = bus_wmask;
          bus_wdata_s = bus_wdata;
        end else begin
          bus_valid_s = 1'b1;
          bus_addr_s  = addr_r + WORD_STEP;
          bus_we_s    = !is_load_r;
          bus_wmask_s = mask8_r[7:4];
          bus_wdata_s = is_load_r ? 32'h0000_0000 : wdata64_r[63:32];
        end
      end
      S_RESP: begin
        rsp_valid_s = 1'b1;
        // Only a rejected request goes straight from IDLE to RESP.
        if (state_r == S_IDLE) begin
          rsp_err_s = 1'b1;
        end else if (is_load_r) begin
          rsp_rd_s   = rd_r;
          rsp_data_s = extend_load(f3_r, load_word_s);
        end else begin
          rsp_rd_s   = 5'd0;
        end
      end
      default: begin
        bus_valid_s = 1'b0;
      end
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b0;
      bus_valid <= 1'b0;
      bus_addr  <= '0;
      bus_we    <= 1'b0;
      bus_wmask <= 4'h0;
      bus_wdata <= 32'h0000_0000;
      rsp_valid <= 1'b0;
      rsp_rd    <= 5'd0;
      rsp_data  <= 32'h0000_0000;
      rsp_err   <= 1'b0;
    end else begin
      req_ready <= req_ready_s;
      bus_valid <= bus_valid_s;
      bus_addr  <= bus_addr_s;
      bus_we    <= bus_we_s;
      bus_wmask <= bus_wmask_s;
      bus_wdata <= bus_wdata_s;
      rsp_valid <= rsp_valid_s;
      rsp_rd    <= rsp_rd_s;
      rsp_data  <= rsp_data_s;
      rsp_err   <= rsp_err_s;
    end
  end

  // Request capture at acceptance.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      is_load_r <= 1'b0;
      f3_r      <= 3'd0;
      off_r     <= 2'd0;
      rd_r      <= 5'd0;
      mask8_r   <= 8'h00;
      wdata64_r <= 64'h0;
      addr_r    <= '0;
      split_r   <= 1'b0;
    end else if (accept_s) begin
      is_load_r <= (req_op == OP_LOAD);
      f3_r      <= req_f3;
      off_r     <= req_addr[1:0];
      rd_r      <= req_rd;
      mask8_r   <= mask8_s;
      wdata64_r <= wdata64_s;
      addr_r    <= base_addr_s;
      split_r   <= split_req_s && SPLIT_EN;
    end else begin
      split_r   <= split_r;
    end
  end

  // First-beat read data held for two-beat load assembly.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rdata_lo_r <= 32'h0000_0000;
    end else if (beat1_rx_s) begin
      rdata_lo_r <= bus_rdata;
    end else begin
      rdata_lo_r <= rdata_lo_r;
    end
  end

endmodule
